// File: rtl/spi_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pwm_pkg
// Description : Shared SPI/PWM types and default word length.
// Revision    : 1.0 - initial release
// ============================================================================

package spi_pwm_pkg;

    localparam int c_DEFAULT_DATA_W = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : spi_bit_counter
// Description : Wrapping bit counter (0..DATA_W-1) with terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================

module spi_bit_counter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= o_tc ? '0 : r_cnt + c_ONE;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/spi_slave_shifter.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_shifter
// Description : SPI mode-0 slave shift engine, MSB first, fed by pre-detected
//               SCLK edge pulses and a synchronised chip select.
// Revision    : 1.0 - initial release
// ============================================================================

module spi_slave_shifter
    import spi_pwm_pkg::*;
#(
    parameter int DATA_W = c_DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              mosi,
    input  logic              sclk_rise,
    input  logic              sclk_fall,
    input  logic [DATA_W-1:0] tx_data,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_load,
    output logic              busy
);

    localparam int c_CNT_W = $clog2(DATA_W + 1);

    spi_state_t          r_state;
    spi_state_t          w_state_nxt;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [DATA_W-1:0]   r_rx_shift;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_miso;
    logic                r_rx_valid;
    logic                r_tx_load;
    logic                r_busy;

    logic                w_load;
    logic                w_rise;
    logic                w_fall_shift;
    logic                w_word_done;
    logic                w_cnt_clr;
    logic [c_CNT_W-1:0]  w_cnt;
    logic                w_cnt_tc;
    logic [DATA_W-1:0]   w_rx_shift_nxt;
    logic [DATA_W-1:0]   w_tx_shift_nxt;

    spi_bit_counter #(
        .DATA_W (DATA_W),
        .CNT_W  (c_CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_cnt_clr),
        .i_inc (w_rise),
        .o_cnt (w_cnt),
        .o_tc  (w_cnt_tc)
    );

    // Rise beats fall when both arrive together; cs_n high beats everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_rise       = 1'b0;
        w_fall_shift = 1'b0;
        w_word_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!cs_n) begin
                    w_state_nxt = ACTIVE;
                    w_load      = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_n) begin
                    w_state_nxt = IDLE;
                end else if (sclk_rise) begin
                    w_rise = 1'b1;
                    if (w_cnt_tc) begin
                        w_word_done = 1'b1;
                        w_load      = 1'b1;
                    end
                end else if (sclk_fall && (w_cnt != '0)) begin
                    w_fall_shift = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_cnt_clr      = (r_state == IDLE) || cs_n;
    assign w_rx_shift_nxt = {r_rx_shift[DATA_W-2:0], mosi};
    assign w_tx_shift_nxt = w_load       ? tx_data :
                            w_fall_shift ? {r_tx_shift[DATA_W-2:0], 1'b0} :
                                           r_tx_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_miso     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_tx_load  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt == ACTIVE);
            r_tx_shift <= w_tx_shift_nxt;
            r_miso     <= (w_state_nxt == ACTIVE) && w_tx_shift_nxt[DATA_W-1];
            r_tx_load  <= w_load;
            r_rx_valid <= w_word_done;
            if (w_rise) begin
                r_rx_shift <= w_rx_shift_nxt;
            end else if (cs_n) begin
                r_rx_shift <= '0;
            end
            if (w_word_done) begin
                r_rx_data <= w_rx_shift_nxt;
            end
        end
    end

    assign miso     = r_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_load  = r_tx_load;
    assign busy     = r_busy;

endmodule

`default_nettype wire
